memacc_lsu: RTL and testbench

Memory-access stage load/store unit. Sits between the execute stage and the mem-to-writeback pipeline register. It issues data-bus requests for loads and stores and aligns and sign-extends load data. It raises misaligned and access-fault exceptions, and asserts `memacc_stall` while a bus transaction is outstanding; the downstream register turns that into a bubble.

---
 rtl/memacc_pkg.sv | 45 ++++
 rtl/memacc_ldext.sv | 24 ++
 rtl/memacc_lsu.sv | 169 ++++++++++++++++
 tb/tb_memacc_lsu.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/memacc_pkg.sv
// Shared constants, state encoding and lane helpers for the memory-access load/store unit.
package memacc_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [4:0] CAUSE_LD_MISALIGN = 5'd4;
    localparam logic [4:0] CAUSE_LD_FAULT    = 5'd5;
    localparam logic [4:0] CAUSE_ST_MISALIGN = 5'd6;
    localparam logic [4:0] CAUSE_ST_FAULT    = 5'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        return ((funct3[1:0] == SZ_HALF) && off[0]) ||
               ((funct3[1:0] == SZ_WORD) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            SZ_BYTE: lane_be = 4'b0001 << off;
            SZ_HALF: lane_be = 4'b0011 << off;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] funct3, input logic [31:0] sdata);
        case (funct3[1:0])
            SZ_BYTE: lane_wdata = {4{sdata[7:0]}};
            SZ_HALF: lane_wdata = {2{sdata[15:0]}};
            default: lane_wdata = sdata;
        endcase
    endfunction

endpackage

// File: rtl/memacc_ldext.sv
// Load data lane selection and sign/zero extension.
import memacc_pkg::*;

module memacc_ldext (
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{off, 3'b000} +: 8];
        half_lane = rdata[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  data = {24'b0, byte_lane};
            F3_LH:   data = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  data = {16'b0, half_lane};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/memacc_lsu.sv
// Memory-access stage: issues data-bus requests, aligns load data, raises
// misaligned/access-fault exceptions and stalls while a transaction is open.
import memacc_pkg::*;

module memacc_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            cpurst,
    input  logic            exe2mem_valid,
    input  logic            exe2mem_load,
    input  logic            exe2mem_store,
    input  logic [2:0]      exe2mem_funct3,
    input  logic [XLEN-1:0] exe2mem_addr,
    input  logic [XLEN-1:0] exe2mem_sdata,
    input  logic            exe2mem_exp,
    input  logic            exe2mem_wr_reg,
    input  logic [4:0]      exe2mem_wr_regindex,
    input  logic [XLEN-1:0] exe2mem_wr_wdata,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [XLEN-1:0] dbus_wdata,
    output logic [3:0]      dbus_be,
    input  logic            dbus_gnt,
    input  logic            dbus_rvalid,
    input  logic [XLEN-1:0] dbus_rdata,
    input  logic            dbus_err,
    output logic            memacc_stall,
    output logic            mem2wb_wr_reg,
    output logic [4:0]      mem2wb_wr_regindex,
    output logic [XLEN-1:0] mem2wb_wr_wdata,
    output logic            mem2wb_exp,
    output logic [4:0]      mem2wb_causecode,
    output logic [XLEN-1:0] mem2wb_mtval
);
    state_t            state_reg, state_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              capture;
    logic [XLEN-1:0]   cap_addr_reg;
    logic [XLEN-1:0]   cap_sdata_reg;
    logic [2:0]        cap_funct3_reg;
    logic              cap_store_reg;
    logic              mem_op;
    logic [XLEN-1:0]   ld_data;

    assign mem_op = exe2mem_valid & (exe2mem_load | exe2mem_store) & ~exe2mem_exp;

    memacc_ldext u_ldext (
        .funct3 (cap_funct3_reg),
        .off    (cap_addr_reg[1:0]),
        .rdata  (dbus_rdata),
        .data   (ld_data)
    );

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state_reg      <= ST_IDLE;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            cap_addr_reg   <= '0;
            cap_sdata_reg  <= '0;
            cap_funct3_reg <= '0;
            cap_store_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            if (capture) begin
                cap_addr_reg   <= exe2mem_addr;
                cap_sdata_reg  <= exe2mem_sdata;
                cap_funct3_reg <= exe2mem_funct3;
                cap_store_reg  <= exe2mem_store;
            end
        end
    end

    always_comb begin
        state_next         = state_reg;
        done_next          = 1'b0;
        err_next           = err_reg;
        capture            = 1'b0;
        dbus_req           = 1'b0;
        dbus_we            = 1'b0;
        dbus_addr          = '0;
        dbus_wdata         = '0;
        dbus_be            = 4'b0000;
        memacc_stall       = 1'b0;
        mem2wb_wr_reg      = exe2mem_valid & exe2mem_wr_reg;
        mem2wb_wr_regindex = exe2mem_valid ? exe2mem_wr_regindex : 5'd0;
        mem2wb_wr_wdata    = exe2mem_valid ? exe2mem_wr_wdata : '0;
        mem2wb_exp         = exe2mem_valid & exe2mem_exp;
        mem2wb_causecode   = 5'd0;
        mem2wb_mtval       = '0;

        case (state_reg)
            ST_IDLE: begin
                if (mem_op) begin
                    mem2wb_wr_reg = exe2mem_load & exe2mem_wr_reg;
                    if (is_misaligned(exe2mem_funct3, exe2mem_addr[1:0])) begin
                        mem2wb_exp       = 1'b1;
                        mem2wb_causecode = exe2mem_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                        mem2wb_mtval     = exe2mem_addr;
                        mem2wb_wr_reg    = 1'b0;
                    end else if (done_reg) begin
                        // Store was granted from REQ last cycle; retire it without re-issuing.
                        mem2wb_wr_reg = 1'b0;
                        if (err_reg) begin
                            mem2wb_exp       = 1'b1;
                            mem2wb_causecode = CAUSE_ST_FAULT;
                            mem2wb_mtval     = exe2mem_addr;
                        end
                    end else begin
                        dbus_req   = 1'b1;
                        dbus_we    = exe2mem_store;
                        dbus_addr  = {exe2mem_addr[XLEN-1:2], 2'b00};
                        dbus_be    = exe2mem_store ? lane_be(exe2mem_funct3, exe2mem_addr[1:0]) : 4'b1111;
                        dbus_wdata = exe2mem_store ? lane_wdata(exe2mem_funct3, exe2mem_sdata) : '0;
                        if (dbus_gnt && exe2mem_store) begin
                            mem2wb_wr_reg = 1'b0;
                            if (dbus_err) begin
                                mem2wb_exp       = 1'b1;
                                mem2wb_causecode = CAUSE_ST_FAULT;
                                mem2wb_mtval     = exe2mem_addr;
                            end
                        end else begin
                            capture      = 1'b1;
                            memacc_stall = 1'b1;
                            state_next   = dbus_gnt ? ST_RESP : ST_REQ;
                        end
                    end
                end
            end
            ST_REQ: begin
                memacc_stall = 1'b1;
                dbus_req     = 1'b1;
                dbus_we      = cap_store_reg;
                dbus_addr    = {cap_addr_reg[XLEN-1:2], 2'b00};
                dbus_be      = cap_store_reg ? lane_be(cap_funct3_reg, cap_addr_reg[1:0]) : 4'b1111;
                dbus_wdata   = cap_store_reg ? lane_wdata(cap_funct3_reg, cap_sdata_reg) : '0;
                if (dbus_gnt) begin
                    if (cap_store_reg) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                        err_next   = dbus_err;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                memacc_stall = 1'b1;
                if (dbus_rvalid) begin
                    memacc_stall    = 1'b0;
                    state_next      = ST_IDLE;
                    mem2wb_wr_reg   = exe2mem_wr_reg & ~dbus_err;
                    mem2wb_wr_wdata = ld_data;
                    if (dbus_err) begin
                        mem2wb_exp       = 1'b1;
                        mem2wb_causecode = CAUSE_LD_FAULT;
                        mem2wb_mtval     = cap_addr_reg;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_memacc_lsu.sv
// Randomized self-checking bench for memacc_lsu against a transaction-level model.
module tb_memacc_lsu;
    logic        clk = 1'b0;
    logic        cpurst;
    logic        exe2mem_valid, exe2mem_load, exe2mem_store, exe2mem_exp, exe2mem_wr_reg;
    logic [2:0]  exe2mem_funct3;
    logic [31:0] exe2mem_addr, exe2mem_sdata, exe2mem_wr_wdata;
    logic [4:0]  exe2mem_wr_regindex;
    logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid, dbus_err;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        memacc_stall, mem2wb_wr_reg, mem2wb_exp;
    logic [4:0]  mem2wb_wr_regindex, mem2wb_causecode;
    logic [31:0] mem2wb_wr_wdata, mem2wb_mtval;

    int checks = 0;
    int errors = 0;
    int txn = 0;

    memacc_lsu #(.XLEN(32)) dut (
        .clk(clk), .cpurst(cpurst),
        .exe2mem_valid(exe2mem_valid), .exe2mem_load(exe2mem_load), .exe2mem_store(exe2mem_store),
        .exe2mem_funct3(exe2mem_funct3), .exe2mem_addr(exe2mem_addr), .exe2mem_sdata(exe2mem_sdata),
        .exe2mem_exp(exe2mem_exp), .exe2mem_wr_reg(exe2mem_wr_reg),
        .exe2mem_wr_regindex(exe2mem_wr_regindex), .exe2mem_wr_wdata(exe2mem_wr_wdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_be(dbus_be), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .dbus_err(dbus_err), .memacc_stall(memacc_stall),
        .mem2wb_wr_reg(mem2wb_wr_reg), .mem2wb_wr_regindex(mem2wb_wr_regindex),
        .mem2wb_wr_wdata(mem2wb_wr_wdata), .mem2wb_exp(mem2wb_exp),
        .mem2wb_causecode(mem2wb_causecode), .mem2wb_mtval(mem2wb_mtval)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic drive_idle();
        exe2mem_valid = 0; exe2mem_load = 0; exe2mem_store = 0; exe2mem_exp = 0;
        exe2mem_funct3 = 0; exe2mem_addr = 0; exe2mem_sdata = 0;
        exe2mem_wr_reg = 0; exe2mem_wr_regindex = 0; exe2mem_wr_wdata = 0;
        dbus_gnt = 0; dbus_rvalid = 0; dbus_err = 0; dbus_rdata = 0;
    endtask

    // One memory op: grant after gd request cycles, load data rd cycles after grant.
    task automatic run_mem(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input int gd, input int rd, input bit want_err);
        int size, off, e_stall, reqs, cyc;
        bit mis, done;
        logic [31:0] e_be, e_wd, e_ld, b;
        logic [4:0] idx;
        size = int'(f3[1:0]);
        off  = int'(addr[1:0]);
        mis  = (size == 1 && addr[0]) || (size == 2 && off != 0);
        e_be = is_load ? 32'd15 : (size == 0 ? (32'd1 << off) : size == 1 ? (32'd3 << off) : 32'd15);
        e_wd = size == 0 ? {24'b0, sdata[7:0]} * 32'h01010101 :
               size == 1 ? {16'b0, sdata[15:0]} * 32'h00010001 : sdata;
        b = rdata >> (8 * off);
        if (size == 0)      e_ld = (!f3[2] && b[7])  ? (b & 32'hFF)   - 32'h100   : (b & 32'hFF);
        else if (size == 1) e_ld = (!f3[2] && b[15]) ? (b & 32'hFFFF) - 32'h10000 : (b & 32'hFFFF);
        else                e_ld = rdata;
        e_stall = is_load ? gd + rd : (gd == 0 ? 0 : gd + 1);
        idx = 5'($urandom_range(1, 31));
        reqs = 0; done = 0; cyc = 0;

        @(negedge clk);
        exe2mem_valid = 1; exe2mem_load = is_load; exe2mem_store = !is_load; exe2mem_exp = 0;
        exe2mem_funct3 = f3; exe2mem_addr = addr; exe2mem_sdata = sdata;
        exe2mem_wr_reg = is_load; exe2mem_wr_regindex = idx; exe2mem_wr_wdata = $urandom;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            cyc = c;
            dbus_gnt    = !mis && (c == gd);
            dbus_rvalid = !mis && is_load && (c == gd + rd);
            dbus_err    = !mis && want_err && (is_load ? (c == gd + rd) : (c == gd));
            dbus_rdata  = (c == gd + rd) ? rdata : $urandom;
            #1;
            if (mis) begin
                check("mis_req", {31'b0, dbus_req}, 0);
                check("mis_stall", {31'b0, memacc_stall}, 0);
                check("mis_exp", {31'b0, mem2wb_exp}, 1);
                check("mis_cause", {27'b0, mem2wb_causecode}, is_load ? 4 : 6);
                check("mis_mtval", mem2wb_mtval, addr);
                check("mis_wr_reg", {31'b0, mem2wb_wr_reg}, 0);
                done = 1;
                break;
            end
            if (dbus_req) begin
                reqs++;
                check("bus_addr", dbus_addr, addr & 32'hFFFF_FFFC);
                check("bus_be", {28'b0, dbus_be}, e_be);
                check("bus_we", {31'b0, dbus_we}, {31'b0, !is_load});
                if (!is_load) check("bus_wdata", dbus_wdata, e_wd);
            end
            if (!memacc_stall) begin
                check("stall_cycles", c, e_stall);
                check("req_cycles", reqs, gd + 1);
                check("exp", {31'b0, mem2wb_exp}, {31'b0, want_err});
                if (want_err) begin
                    check("cause", {27'b0, mem2wb_causecode}, is_load ? 5 : 7);
                    check("mtval", mem2wb_mtval, addr);
                end
                check("wr_reg", {31'b0, mem2wb_wr_reg}, {31'b0, is_load && !want_err});
                if (is_load && !want_err) begin
                    check("ld_data", mem2wb_wr_wdata, e_ld);
                    check("ld_index", {27'b0, mem2wb_wr_regindex}, {27'b0, idx});
                end
                done = 1;
                break;
            end
        end
        if (!done) check("timeout", 0, 1);
        $display("txn %0d %s f3=%0d addr=%h gnt_dly=%0d rv_dly=%0d err=%0d mis=%0d cycles=%0d",
                 txn, is_load ? "LOAD " : "STORE", f3, addr, gd, rd, want_err, mis, cyc);
        txn++;
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        drive_idle();
        cpurst = 1;
        #12;
        check("rst_outputs_zero", {31'b0, |{dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
              memacc_stall, mem2wb_wr_reg, mem2wb_wr_regindex, mem2wb_wr_wdata, mem2wb_exp,
              mem2wb_causecode, mem2wb_mtval}}, 0);
        @(negedge clk);
        cpurst = 0;

        // ALU pass-through
        @(negedge clk);
        exe2mem_valid = 1; exe2mem_wr_reg = 1; exe2mem_wr_regindex = 5'd3; exe2mem_wr_wdata = 32'h1234;
        #1;
        check("alu_wdata", mem2wb_wr_wdata, 32'h1234);
        check("alu_stall", {31'b0, memacc_stall}, 0);
        check("alu_req", {31'b0, dbus_req}, 0);
        $display("txn %0d ALU wdata=%h", txn, mem2wb_wr_wdata);
        txn++;

        // Upstream exception suppresses a load
        @(negedge clk);
        exe2mem_load = 1; exe2mem_exp = 1; exe2mem_wr_reg = 0; exe2mem_addr = 32'h40;
        #1;
        check("upexp_req", {31'b0, dbus_req}, 0);
        check("upexp_exp", {31'b0, mem2wb_exp}, 1);
        check("upexp_stall", {31'b0, memacc_stall}, 0);
        $display("txn %0d UPEXP exp=%0d", txn, mem2wb_exp);
        txn++;
        @(negedge clk);
        drive_idle();

        run_mem(1, 3'b000, 32'h1003, 32'h0, 32'h80A5_5A11, 0, 2, 0);  // LB
        run_mem(1, 3'b100, 32'h1003, 32'h0, 32'h80A5_5A11, 0, 2, 0);  // LBU
        run_mem(0, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 3, 1, 0);  // SH, late grant
        run_mem(1, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 1, 0);          // LW misaligned
        run_mem(0, 3'b010, 32'h4008, 32'hDEAD_BEEF, 32'h0, 0, 1, 1);  // SW bus error
        run_mem(0, 3'b010, 32'h4008, 32'hDEAD_BEEF, 32'h0, 2, 1, 1);  // SW bus error after wait
        run_mem(1, 3'b001, 32'h5002, 32'h0, 32'h9876_1234, 1, 3, 1);  // LH bus error

        // Reset while waiting for load data, then a stray rvalid
        @(negedge clk);
        exe2mem_valid = 1; exe2mem_load = 1; exe2mem_funct3 = 3'b010; exe2mem_addr = 32'h6000;
        exe2mem_wr_reg = 1; exe2mem_wr_regindex = 5'd9; dbus_gnt = 1;
        @(negedge clk);
        dbus_gnt = 0;
        #1;
        check("resp_stall", {31'b0, memacc_stall}, 1);
        cpurst = 1;
        #1;
        drive_idle();
        #1;
        cpurst = 0;
        @(negedge clk);
        dbus_rvalid = 1; dbus_rdata = 32'hCAFE_F00D;
        #1;
        check("stray_stall", {31'b0, memacc_stall}, 0);
        check("stray_req", {31'b0, dbus_req}, 0);
        check("stray_wr_reg", {31'b0, mem2wb_wr_reg}, 0);
        check("stray_wdata", mem2wb_wr_wdata, 0);
        $display("txn %0d RESET_IN_RESP stall=%0d", txn, memacc_stall);
        txn++;
        @(negedge clk);
        drive_idle();

        for (int i = 0; i < 60; i++) begin
            bit ld, er;
            logic [2:0] f3;
            logic [31:0] a;
            ld = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, ld ? 4 : 2))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
                else if (f3[1:0] == 2'b01) a[0] = 1'b0;
            end
            er = $urandom_range(0, 7) == 0;
            run_mem(ld, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3), er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
